// File: rtl/logic_gates_checker.sv
// Stimulus/response checker for a two-input, six-output basic-gate block.
// Walks {A,B} through 00,01,10,11, samples Z after a settle delay and accumulates mismatches.
module logic_gates_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic [5:0] Z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [5:0] err_mask,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pass_q, pass_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic [5:0] err_mask_q, err_mask_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [5:0] exp_z, mm;

  // Reference gate outputs for the vector currently on A/B
  assign exp_z = {~(A ^ B), A ^ B, ~(A | B), ~(A & B), A | B, A & B};
  assign mm    = Z ^ exp_z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= 4'd0;
      pass_q     <= 1'b0;
      err_cnt_q  <= 3'd0;
      err_mask_q <= 6'd0;
      fail_vec_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      err_mask_q <= err_mask_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    err_mask_d = err_mask_q;
    fail_vec_d = fail_vec_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          idx_d      = 2'd0;
          cnt_d      = CNT_INIT;
          pass_d     = 1'b0;
          err_cnt_d  = 3'd0;
          err_mask_d = 6'd0;
          fail_vec_d = 4'd0;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CHECK: begin
        err_mask_d = err_mask_q | mm;
        if (|mm) begin
          err_cnt_d         = err_cnt_q + 3'd1;
          fail_vec_d[idx_q] = 1'b1;
        end
        if (idx_q == 2'd3) begin
          // Verdict includes the final vector's result, so use the next-state count
          state_d = DONE;
          idx_d   = 2'd0;
          pass_d  = (err_cnt_d == 3'd0);
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + 2'd1;
          cnt_d   = CNT_INIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign A         = idx_q[1];
  assign B         = idx_q[0];
  assign busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_cnt_q;
  assign err_mask  = err_mask_q;
  assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_logic_gates_checker.sv
// Directed bench for logic_gates_checker: ideal and faulty gate models, restart/reset corners,
// plus a second instance with zero settle cycles.
module tb_logic_gates_checker;

  logic       clk = 1'b0;
  logic       rst, start, A, B, busy, done, pass;
  logic [5:0] Z, err_mask;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  logic       start0, A0, B0, busy0, done0, pass0;
  logic [5:0] Z0, err_mask0;
  logic [2:0] err_count0;
  logic [3:0] fail_vec0;

  int zmode = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Gate model: 0 ideal, 1 XOR output stuck at 0, 2 all outputs inverted
  always_comb begin
    Z = {~(A ^ B), A ^ B, ~(A | B), ~(A & B), A | B, A & B};
    if (zmode == 1) Z[4] = 1'b0;
    else if (zmode == 2) Z = ~Z;
  end
  assign Z0 = {~(A0 ^ B0), A0 ^ B0, ~(A0 | B0), ~(A0 & B0), A0 | B0, A0 & B0};

  logic_gates_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Z(Z), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .err_mask(err_mask), .fail_vec(fail_vec));

  logic_gates_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .A(A0), .B(B0), .Z(Z0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err_count0), .err_mask(err_mask0), .fail_vec(fail_vec0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic results(input logic [2:0] ec, input logic [5:0] em, input logic [3:0] fv,
                         input logic ps);
    chk("err_count", err_count, ec);
    chk("err_mask", err_mask, em);
    chk("fail_vec", fail_vec, fv);
    chk("pass", pass, ps);
  endtask

  // Full run on the SETTLE_CYCLES=2 instance, entered 1 ns after an edge with dut in IDLE
  task automatic run_chk(input int m, input logic [2:0] ec, input logic [5:0] em,
                         input logic [3:0] fv, input logic ps);
    zmode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk("run_busy", busy, 1);
      chk("run_done_early", done, 0);
      chk("run_AB", {A, B}, (c - 1) / 4);
      tick();
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_AB", {A, B}, 0);
    results(ec, em, fv, ps);
    tick();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
    results(ec, em, fv, ps);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start0 = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_AB", {A, B}, 0);
    results(3'd0, 6'd0, 4'd0, 1'b0);
    rst = 1'b0;
    tick();

    run_chk(0, 3'd0, 6'b000000, 4'b0000, 1'b1);
    run_chk(1, 3'd2, 6'b010000, 4'b0110, 1'b0);
    run_chk(2, 3'd4, 6'b111111, 4'b1111, 1'b0);

    // Restart attempts mid-run and during DONE are ignored; acceptance clears results
    zmode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", busy, 1);
    results(3'd0, 6'd0, 4'd0, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      start = (c == 5);
      chk("rs_done", done, 0);
      chk("rs_busy", busy, 1);
      chk("rs_AB", {A, B}, (c - 1) / 4);
      tick();
    end
    start = 1'b1;
    chk("rs_done_pulse", done, 1);
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rs_no_restart_busy", busy, 0);
      chk("rs_no_second_done", done, 0);
      if (c < 3) tick();
    end
    results(3'd0, 6'd0, 4'd0, 1'b1);
    run_chk(0, 3'd0, 6'b000000, 4'b0000, 1'b1);

    // Reset mid-run with errors already accumulated
    zmode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    chk("pre_rst_err_count", err_count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_AB", {A, B}, 0);
    results(3'd0, 6'd0, 4'd0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      chk("post_rst_no_done", done, 0);
      tick();
    end
    run_chk(0, 3'd0, 6'b000000, 4'b0000, 1'b1);

    // Zero settle cycles: each vector held 2 cycles, done at k+9
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("s0_busy", busy0, 1);
      chk("s0_done_early", done0, 0);
      chk("s0_AB", {A0, B0}, (c - 1) / 2);
      tick();
    end
    chk("s0_done", done0, 1);
    tick();
    chk("s0_pass", pass0, 1);
    chk("s0_err_count", err_count0, 0);
    chk("s0_err_mask", err_mask0, 0);
    chk("s0_fail_vec", fail_vec0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
